grid_mem_arbiter: RTL

GRID_MEM_ARBITER -- requirements
Module: grid_mem_arbiter

---
 rtl/grid_pkg.sv | 11 +
 rtl/grid_clear_seq.sv | 62 ++++++
 rtl/grid_mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared sizing and clear-sequencer state type for the grid memory blocks.
package grid_pkg;
  localparam int ROWS   = 20;
  localparam int COLS   = 14;
  localparam int ADDR_W = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;
endpackage

// File: rtl/grid_clear_seq.sv
// Grid clear sequencer: walks rows 0..ROWS-1 issuing zero writes, pausing
// whenever the arbiter gives the slot to the display.
module grid_clear_seq
  import grid_pkg::*;
#(
  parameter int ROWS = grid_pkg::ROWS
) (
  input  logic              gfx_clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              yield_i,
  output logic              busy_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] row_o
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  clr_state_e        state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] row_q;

  always_ff @(posedge gfx_clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      row_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            row_q   <= '0;
          end
        end
        CLEAR: begin
          // A yielded cycle leaves the counter parked on the same row.
          if (!yield_i) begin
            if (row_q == LAST_ROW) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              row_q   <= '0;
            end else begin
              row_q <= row_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          row_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign we_o   = busy_q && !yield_i;
  assign row_o  = row_q;

endmodule

// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter: display fetch > clear sequencer > game logic,
// one RAM access per cycle, out-of-grid addresses never reach the RAM.
module grid_mem_arbiter
  import grid_pkg::*;
#(
  parameter int ROWS = grid_pkg::ROWS,
  parameter int COLS = grid_pkg::COLS
) (
  input  logic              gfx_clk,
  input  logic              rst,
  input  logic              disp_fetch,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [COLS-1:0]   disp_data,
  output logic              disp_overrun,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [COLS-1:0]   game_wdata,
  output logic              game_gnt,
  output logic              game_rvalid,
  output logic [COLS-1:0]   game_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [COLS-1:0]   mem_wdata,
  input  logic [COLS-1:0]   mem_rdata
);

  function automatic logic in_grid(input logic [ADDR_W-1:0] a);
    return 32'(a) < ROWS;
  endfunction

  logic              pend_q, pend_d;
  logic              overrun_q, overrun_d;
  logic              inflight_q;
  logic              disp_oob_q;
  logic              rvalid_q;
  logic              game_oob_q;
  logic [ADDR_W-1:0] disp_addr_q;
  logic [COLS-1:0]   disp_data_q;

  logic              disp_issue;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_row;

  // A new display read waits until the previous one has returned its data,
  // so each fetch owns the mem_rdata cycle that follows its issue.
  assign disp_issue = pend_q && !inflight_q;

  grid_clear_seq #(
    .ROWS(ROWS)
  ) u_clear (
    .gfx_clk (gfx_clk),
    .rst     (rst),
    .start_i (clr_start),
    .yield_i (disp_issue),
    .busy_o  (clr_busy),
    .we_o    (clr_we),
    .row_o   (clr_row)
  );

  // An arriving fetch also holds off the game so the display wins the next slot.
  assign game_gnt = !rst && game_req && !disp_fetch && !pend_q && !clr_busy;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      if (disp_issue) begin
        if (in_grid(disp_addr_q)) mem_addr = disp_addr_q;
      end else if (clr_we) begin
        mem_we   = 1'b1;
        mem_addr = clr_row;
      end else if (game_gnt && in_grid(game_addr)) begin
        mem_addr  = game_addr;
        mem_we    = game_we;
        mem_wdata = game_wdata;
      end
    end
  end

  always_comb begin
    pend_d    = pend_q;
    overrun_d = overrun_q;
    if (disp_fetch) begin
      pend_d = 1'b1;
      if (pend_q && !disp_issue) overrun_d = 1'b1;
    end else if (disp_issue) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge gfx_clk) begin
    if (rst) begin
      pend_q      <= 1'b0;
      overrun_q   <= 1'b0;
      inflight_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      disp_data_q <= '0;
    end else begin
      pend_q     <= pend_d;
      overrun_q  <= overrun_d;
      inflight_q <= disp_issue;
      rvalid_q   <= game_gnt && !game_we;
      if (inflight_q) disp_data_q <= disp_oob_q ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge gfx_clk) begin
    if (disp_fetch) disp_addr_q <= disp_addr;
    disp_oob_q <= !in_grid(disp_addr_q);
    game_oob_q <= !in_grid(game_addr);
  end

  assign disp_data    = disp_data_q;
  assign disp_overrun = overrun_q;
  assign game_rvalid  = rvalid_q;
  assign game_rdata   = (rvalid_q && !game_oob_q) ? mem_rdata : '0;

endmodule
